// File: rtl/serial_csel_subtractor.sv
// -----------------------------------------------------------------------------
// serial_csel_subtractor
//
// Multi-cycle subtractor computing A - B - borrow_i modulo 2^DATA_WIDTH.
// The subtraction is done as A + ~B + carry, with carry = ~borrow.
// Each cycle one BLOCK_WIDTH-bit slice is processed, starting with the least
// significant slice. Two sums are prepared for every slice, one for carry-in 0
// and one for carry-in 1. The registered carry then selects between them.
// A single operation is in flight at a time, under a valid/ready handshake.
//
// Ports
//   clk_i        : clock. All state changes on its rising edge.
//   rst_i        : synchronous, active-high reset. It has priority over all
//                  other inputs.
//   operand_A_i  : minuend.
//   operand_B_i  : subtrahend.
//   borrow_i     : borrow-in.
//   valid_i      : request strobe. It is accepted only while ready_o is high.
//   ready_o      : high in IDLE, when a request can be accepted.
//   result_o     : difference. Sample it only while valid_o is high.
//   borrow_o     : unsigned borrow-out (A < B + borrow_i).
//   overflow_o   : two's-complement overflow of the subtraction.
//   valid_o      : result and flags are valid. Held until ready_i is high.
//   ready_i      : consumer acknowledge of the result.
// -----------------------------------------------------------------------------
module serial_csel_subtractor #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] operand_A_i,
  input  logic [DATA_WIDTH-1:0] operand_B_i,
  input  logic                  borrow_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  borrow_o,
  output logic                  overflow_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int NUM_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;
  localparam int CNT_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int MSB        = DATA_WIDTH - 1;

  // The slice logic assumes that the operand width divides into whole slices.
  generate
    if (DATA_WIDTH % BLOCK_WIDTH != 0) begin : g_bad_width
      $error("serial_csel_subtractor: DATA_WIDTH must be a multiple of BLOCK_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]  a_q, b_q;
  logic                   carry_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BLOCK_WIDTH-1:0] res_q [NUM_BLOCKS];
  logic                   borrow_q, overflow_q;

  // Operands are viewed as arrays of slices, indexed by the block counter.
  logic [BLOCK_WIDTH-1:0] a_sl [NUM_BLOCKS];
  logic [BLOCK_WIDTH-1:0] b_sl [NUM_BLOCKS];

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_slices
    assign a_sl[i] = a_q[i*BLOCK_WIDTH +: BLOCK_WIDTH];
    assign b_sl[i] = b_q[i*BLOCK_WIDTH +: BLOCK_WIDTH];
    assign result_o[i*BLOCK_WIDTH +: BLOCK_WIDTH] = res_q[i];
  end

  // Carry-select slice: both sums are available before the carry is known.
  // The extra top bit of each sum is that slice's carry-out.
  logic [BLOCK_WIDTH:0]   sum0, sum1;
  logic [BLOCK_WIDTH-1:0] sum_sel;
  logic                   carry_sel;

  assign sum0 = {1'b0, a_sl[cnt_q]} + {1'b0, ~b_sl[cnt_q]};
  assign sum1 = {1'b0, a_sl[cnt_q]} + {1'b0, ~b_sl[cnt_q]} + {{BLOCK_WIDTH{1'b0}}, 1'b1};
  assign {carry_sel, sum_sel} = carry_q ? sum1 : sum0;

  logic accept, last_slice;
  assign accept     = (state_q == IDLE) && valid_i;
  assign last_slice = (cnt_q == CNT_W'(NUM_BLOCKS - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the values from before the edge, whatever the block order.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: state_d gets a default first. Otherwise, a path that does not
    // assign it would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_i)    state_d = COMPUTE;
      COMPUTE: if (last_slice) state_d = DONE;
      DONE:    if (ready_i)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      // NOTE: the result slices are the visible result register, not scratch
      // storage. They must read as zero after reset, so they are cleared here.
      for (int i = 0; i < NUM_BLOCKS; i++) res_q[i] <= '0;
    end else if (accept) begin
      a_q     <= operand_A_i;
      b_q     <= operand_B_i;
      carry_q <= ~borrow_i;
      cnt_q   <= '0;
    end else if (state_q == COMPUTE) begin
      res_q[cnt_q] <= sum_sel;
      carry_q      <= carry_sel;
      cnt_q        <= cnt_q + CNT_W'(1);
      if (last_slice) begin
        // sum_sel holds the result MSB on this edge. res_q has not been
        // written yet, so the flags are taken from sum_sel directly.
        borrow_q   <= ~carry_sel;
        overflow_q <= (a_q[MSB] ^ b_q[MSB]) & (sum_sel[BLOCK_WIDTH-1] ^ a_q[MSB]);
      end
    end
  end

  assign borrow_o   = borrow_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_serial_csel_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_csel_subtractor
//
// Scoreboard bench for serial_csel_subtractor with the default parameters.
// When the driver issues a request, it pushes the expected result into a
// queue. The expected values are hand-computed, and each entry also holds the
// cycle on which valid_o should rise. A separate monitor samples on the
// falling edge. It checks the rise cycle, and it pops and compares the entry
// on each result handshake.
// -----------------------------------------------------------------------------
module tb_serial_csel_subtractor;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] operand_A_i, operand_B_i;
  logic          borrow_i, valid_i, ready_i;
  logic          ready_o, borrow_o, overflow_o, valid_o;
  logic [DW-1:0] result_o;

  serial_csel_subtractor #(.DATA_WIDTH(32), .BLOCK_WIDTH(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .operand_A_i (operand_A_i),
    .operand_B_i (operand_B_i),
    .borrow_i    (borrow_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .result_o    (result_o),
    .borrow_o    (borrow_o),
    .overflow_o  (overflow_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] res;
    logic          bo;
    logic          ov;
    int            rise;
    string         tag;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          bi;
    logic [DW-1:0] res;
    logic          bo;
    logic          ov;
  } vec_t;

  // Directed vectors with hand-computed results.
  vec_t vecs[7] = '{
    '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0},
    '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1},
    '{32'h0000_000A, 32'h0000_000A, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1},
    '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_5677, 1'b0, 1'b0}
  };

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic prev_v = 1'b0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid_o && !prev_v) begin
        if (sb.size() == 0) check("unexpected_valid", valid_o, 1'b0);
        else                check({sb[0].tag, "_latency"}, cyc, sb[0].rise);
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("handshake_without_request", valid_o, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_result"},   result_o,   e.res);
          check({e.tag, "_borrow"},   borrow_o,   e.bo);
          check({e.tag, "_overflow"}, overflow_o, e.ov);
        end
      end
    end
    prev_v = valid_o;
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!ready_o && n < 50);
    if (!ready_o) check("ready_timeout", ready_o, 1'b1);
  endtask

  task automatic issue(input vec_t v, input string tag, input bit expect_result);
    exp_t e;
    wait_ready();
    @(posedge clk_i); #1;
    operand_A_i = v.a;
    operand_B_i = v.b;
    borrow_i    = v.bi;
    valid_i     = 1'b1;
    if (expect_result) begin
      e.res  = v.res;
      e.bo   = v.bo;
      e.ov   = v.ov;
      e.rise = cyc + 9;  // the accept edge is at cyc+1, and valid_o rises 8 edges later
      e.tag  = tag;
      sb.push_back(e);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!valid_o) check("valid_timeout", valid_o, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp, junk, ab;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    operand_A_i = '0; operand_B_i = '0; borrow_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    check("reset_ready",    ready_o,    1'b1);
    check("reset_valid",    valid_o,    1'b0);
    check("reset_result",   result_o,   32'h0);
    check("reset_borrow",   borrow_o,   1'b0);
    check("reset_overflow", overflow_o, 1'b0);

    // Directed vectors. The consumer is always ready.
    foreach (vecs[i]) issue(vecs[i], $sformatf("vec%0d", i), 1'b1);
    wait_ready();

    // Backpressure. 6 - 9 = 0xFFFFFFFD with a borrow. A request pulsed
    // during COMPUTE must be ignored.
    bp   = '{32'h6, 32'h9, 1'b0, 32'hFFFF_FFFD, 1'b1, 1'b0};
    junk = '{32'h0000_FFFF, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0};
    ready_i = 1'b0;
    issue(bp, "bp", 1'b1);
    @(posedge clk_i); #1;
    operand_A_i = junk.a; operand_B_i = junk.b; borrow_i = junk.bi;
    valid_i = 1'b1;
    check("ready_low_in_compute", ready_o, 1'b0);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    wait_valid();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check($sformatf("bp_hold_valid%0d", k),  valid_o,    1'b1);
      check($sformatf("bp_hold_result%0d", k), result_o,   32'hFFFF_FFFD);
      check($sformatf("bp_hold_borrow%0d", k), borrow_o,   1'b1);
      check($sformatf("bp_hold_ovf%0d", k),    overflow_o, 1'b0);
    end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("bp_ready_back", ready_o, 1'b1);
    check("bp_valid_drop", valid_o, 1'b0);
    check("bp_result_kept", result_o, 32'hFFFF_FFFD);

    // Reset abort: rst_i goes high 4 cycles after the accept edge.
    ab = '{32'h100, 32'h1, 1'b0, 32'hFF, 1'b0, 1'b0};
    wait_ready();
    @(posedge clk_i); #1;
    operand_A_i = ab.a; operand_B_i = ab.b; borrow_i = ab.bi;
    valid_i = 1'b1;
    @(posedge clk_i); #1;              // accept edge
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;              // reset edge, 4 cycles after the accept edge
    rst_i = 1'b0;
    check("abort_ready",    ready_o,    1'b1);
    check("abort_valid",    valid_o,    1'b0);
    check("abort_result",   result_o,   32'h0);
    check("abort_borrow",   borrow_o,   1'b0);
    check("abort_overflow", overflow_o, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      check($sformatf("abort_no_valid%0d", k), valid_o, 1'b0);
    end

    // The unit must still work after the abort.
    issue(vecs[0], "post_abort", 1'b1);
    wait_ready();
    repeat (2) @(negedge clk_i);
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
